// File: rtl/wir_param_if.sv
// Wrapper instruction register port bundle: WSP control strobes in,
// decoded instruction, WBR controls and error flags out.
interface wir_param_if #(
  parameter int WIR_WIDTH = 6
) ();
  logic                 WSI;
  logic                 SelectWIR;
  logic                 CaptureWR;
  logic                 ShiftWR;
  logic                 UpdateWR;
  logic                 wir_so;
  logic [WIR_WIDTH-1:0] instr;
  logic                 wpp_bypass;
  logic                 extest;
  logic                 intest;
  logic                 scanmode;
  logic                 mbistmode;
  logic                 wbr_concat;
  logic                 hold_inputs;
  logic                 hold_outputs;
  logic                 wse_inputs;
  logic                 wse_outputs;
  logic                 len_err;
  logic                 proto_err;

  modport master (
    output WSI, SelectWIR, CaptureWR, ShiftWR, UpdateWR,
    input  wir_so, instr, wpp_bypass, extest, intest, scanmode, mbistmode,
           wbr_concat, hold_inputs, hold_outputs, wse_inputs, wse_outputs,
           len_err, proto_err
  );

  modport slave (
    input  WSI, SelectWIR, CaptureWR, ShiftWR, UpdateWR,
    output wir_so, instr, wpp_bypass, extest, intest, scanmode, mbistmode,
           wbr_concat, hold_inputs, hold_outputs, wse_inputs, wse_outputs,
           len_err, proto_err
  );
endinterface

// File: rtl/wir_param.sv
// Parameterised wrapper instruction register: capture/shift/update via WSP
// strobes, one-hot mode decode, WBR hold/shift-enable and sticky error flags.
module wir_param #(
  parameter int                   WIR_WIDTH   = 6,
  parameter logic [WIR_WIDTH-1:0] CAPTURE_VAL = WIR_WIDTH'(1),
  parameter bit                   CNT_CHECK   = 1'b1,
  parameter int                   OP_BYPASS   = 0,
  parameter int                   OP_EXTEST   = 1,
  parameter int                   OP_INTEST   = 2,
  parameter int                   OP_SCAN     = 3,
  parameter int                   OP_MBIST    = 4,
  parameter int                   OP_CONCAT   = 5
) (
  input  logic      WRCK,
  input  logic      WRSTN,
  wir_param_if.slave bus
);

  // Counter must reach WIR_WIDTH+1 so an over-long shift is distinguishable.
  localparam int CNT_W = $clog2(WIR_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIR_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [WIR_WIDTH-1:0] OPC_BYPASS = WIR_WIDTH'(OP_BYPASS);
  localparam logic [WIR_WIDTH-1:0] OPC_EXTEST = WIR_WIDTH'(OP_EXTEST);
  localparam logic [WIR_WIDTH-1:0] OPC_INTEST = WIR_WIDTH'(OP_INTEST);
  localparam logic [WIR_WIDTH-1:0] OPC_SCAN   = WIR_WIDTH'(OP_SCAN);
  localparam logic [WIR_WIDTH-1:0] OPC_MBIST  = WIR_WIDTH'(OP_MBIST);
  localparam logic [WIR_WIDTH-1:0] OPC_CONCAT = WIR_WIDTH'(OP_CONCAT);

  logic [WIR_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [WIR_WIDTH-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 lenErr_q, lenErr_d;
  logic                 protoErr_q, protoErr_d;
  logic                 multiStrobe;

  logic modeBypass, modeExtest, modeIntest, modeScan, modeMbist, modeConcat;

  assign multiStrobe = (bus.CaptureWR & bus.ShiftWR) |
                       (bus.CaptureWR & bus.UpdateWR) |
                       (bus.ShiftWR & bus.UpdateWR);

  // Conflicting strobes only flag an error; every other register holds.
  always_comb begin
    shiftReg_d = shiftReg_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    lenErr_d   = lenErr_q;
    protoErr_d = protoErr_q;
    if (bus.SelectWIR) begin
      if (multiStrobe) begin
        protoErr_d = 1'b1;
      end else if (bus.CaptureWR) begin
        shiftReg_d = CAPTURE_VAL;
        cnt_d      = '0;
      end else if (bus.ShiftWR) begin
        shiftReg_d = {bus.WSI, shiftReg_q[WIR_WIDTH-1:1]};
        if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (bus.UpdateWR) begin
        cnt_d = '0;
        if (!CNT_CHECK || (cnt_q == CNT_FULL)) begin
          instr_d = shiftReg_q;
        end else begin
          lenErr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      shiftReg_q <= '0;
      instr_q    <= OPC_BYPASS;
      cnt_q      <= '0;
      lenErr_q   <= 1'b0;
      protoErr_q <= 1'b0;
    end else begin
      shiftReg_q <= shiftReg_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      lenErr_q   <= lenErr_d;
      protoErr_q <= protoErr_d;
    end
  end

  // Unrecognised opcodes fall through to bypass, keeping the decode one-hot.
  always_comb begin
    modeBypass = 1'b0;
    modeExtest = 1'b0;
    modeIntest = 1'b0;
    modeScan   = 1'b0;
    modeMbist  = 1'b0;
    modeConcat = 1'b0;
    if (instr_q == OPC_EXTEST) begin
      modeExtest = 1'b1;
    end else if (instr_q == OPC_INTEST) begin
      modeIntest = 1'b1;
    end else if (instr_q == OPC_SCAN) begin
      modeScan = 1'b1;
    end else if (instr_q == OPC_MBIST) begin
      modeMbist = 1'b1;
    end else if (instr_q == OPC_CONCAT) begin
      modeConcat = 1'b1;
    end else begin
      modeBypass = 1'b1;
    end
  end

  assign bus.wir_so       = bus.SelectWIR ? shiftReg_q[0] : 1'b0;
  assign bus.instr        = instr_q;
  assign bus.wpp_bypass   = modeBypass;
  assign bus.extest       = modeExtest;
  assign bus.intest       = modeIntest;
  assign bus.scanmode     = modeScan;
  assign bus.mbistmode    = modeMbist;
  assign bus.wbr_concat   = modeConcat;
  assign bus.hold_inputs  = modeIntest | modeScan | modeMbist;
  assign bus.hold_outputs = modeExtest | modeIntest | modeScan | modeMbist;
  assign bus.wse_inputs   = bus.ShiftWR & ~bus.SelectWIR & (modeExtest | modeIntest | modeConcat);
  assign bus.wse_outputs  = bus.ShiftWR & ~bus.SelectWIR & (modeExtest | modeIntest | modeConcat);
  assign bus.len_err      = lenErr_q;
  assign bus.proto_err    = protoErr_q;

endmodule

// File: tb/tb_wir_param.sv
// Scoreboard bench for wir_param: stimulus queues hand-computed observation
// vectors, a negedge monitor pops and compares them against the DUT outputs.
module tb_wir_param;
  localparam int W = 6;

  // Observation layout: {wir_so, instr[5:0], bypass, extest, intest, scan,
  // mbist, concat, hold_in, hold_out, wse_in, wse_out, len_err, proto_err}
  localparam logic [18:0] ALL_BITS = '1;
  localparam logic [18:0] SO_ONLY  = 19'h40000;

  logic WRCK = 1'b0;
  logic WRSTN;

  wir_param_if #(.WIR_WIDTH(W)) bus ();

  wir_param #(.WIR_WIDTH(W)) dut (
    .WRCK  (WRCK),
    .WRSTN (WRSTN),
    .bus   (bus)
  );

  always #5 WRCK = ~WRCK;

  logic [18:0] obs;
  assign obs = {bus.wir_so, bus.instr, bus.wpp_bypass, bus.extest, bus.intest,
                bus.scanmode, bus.mbistmode, bus.wbr_concat, bus.hold_inputs,
                bus.hold_outputs, bus.wse_inputs, bus.wse_outputs,
                bus.len_err, bus.proto_err};

  string       nameQ[$];
  logic [18:0] expQ[$];
  logic [18:0] maskQ[$];
  logic        checkReq;
  int          checks = 0;
  int          errors = 0;
  string       monName;
  logic [18:0] monExp;
  logic [18:0] monMask;

  // Monitor: consumes one queued expectation whenever a check is requested.
  always @(negedge WRCK) begin
    if (checkReq) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_underflow actual=%b required=queued entry", obs);
      end else begin
        monName = nameQ.pop_front();
        monExp  = expQ.pop_front();
        monMask = maskQ.pop_front();
        if (((obs ^ monExp) & monMask) !== 19'b0) begin
          errors++;
          $display("[TB] FAIL %s actual=%b required=%b mask=%b",
                   monName, obs, monExp, monMask);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic sel, input logic cap, input logic sh,
                               input logic up, input logic wsi);
    bus.SelectWIR = sel;
    bus.CaptureWR = cap;
    bus.ShiftWR   = sh;
    bus.UpdateWR  = up;
    bus.WSI       = wsi;
  endtask

  task automatic clockOne();
    @(posedge WRCK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [18:0] expVal,
                             input logic [18:0] mask);
    nameQ.push_back(name);
    expQ.push_back(expVal);
    maskQ.push_back(mask);
    checkReq = 1'b1;
    @(negedge WRCK);
    #1;
    checkReq = 1'b0;
  endtask

  task automatic loadInstr(input logic [5:0] bits, input int n);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    clockOne();
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, bits[i]);
      clockOne();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    clockOne();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [5:0]  intestBits = 6'b000010;
  logic [5:0]  soSeq      = 6'b000001;
  logic [5:0]  tblOp  [3] = '{6'd4, 6'd5, 6'd0};
  logic        tblSh  [3] = '{1'b0, 1'b1, 1'b0};
  logic [18:0] tblExp [3] = '{19'b0_000100_000010_11_00_11,
                              19'b0_000101_000001_00_11_11,
                              19'b0_000000_100000_00_00_11};

  initial begin
    checkReq = 1'b0;
    WRSTN    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) clockOne();
    checkOutput("reset_state", 19'b0_000000_100000_00_00_00, ALL_BITS);
    WRSTN = 1'b1;
    clockOne();

    // Capture then shift 000010 LSB-first, watching wir_so before each shift.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    clockOne();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, intestBits[i]);
      checkOutput($sformatf("so_seq%0d", i), {soSeq[i], 18'b0}, SO_ONLY);
      clockOne();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    clockOne();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("load_intest", 19'b0_000010_001000_11_00_00, ALL_BITS);

    loadInstr(6'h3F, 6);
    checkOutput("load_3F_fallback", 19'b0_111111_100000_00_00_00, ALL_BITS);

    loadInstr(6'b000001, 5);
    checkOutput("short_update_rejected", 19'b0_111111_100000_00_00_10, ALL_BITS);
    loadInstr(6'b000001, 6);
    checkOutput("full_update_extest", 19'b0_000001_010000_01_00_10, ALL_BITS);

    // Shift with the WIR deselected drives the WBR enables, not shift_reg.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("wse_extest", 19'b0_000001_010000_01_11_10, ALL_BITS);
    clockOne();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sel0_shift_ignored", {1'b1, 18'b0}, SO_ONLY);

    // Conflicting strobes mid-load; the load only lands if cnt stayed at 3.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    clockOne();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    clockOne();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    clockOne();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    clockOne();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    clockOne();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("proto_err_set", 19'b0_000001_010000_01_00_11, ALL_BITS);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      clockOne();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    clockOne();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_proto_scan", 19'b0_000011_000100_11_00_11, ALL_BITS);

    for (int k = 0; k < 3; k++) begin
      loadInstr(tblOp[k], 6);
      applyStimulus(1'b0, 1'b0, tblSh[k], 1'b0, 1'b0);
      checkOutput($sformatf("decode_op%0d", tblOp[k]), tblExp[k], ALL_BITS);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset asserted between edges while shifting with EXTEST active.
    loadInstr(6'b000001, 6);
    checkOutput("pre_reset_extest", 19'b0_000001_010000_01_00_11, ALL_BITS);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    clockOne();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    clockOne();
    clockOne();
    WRSTN = 1'b0;
    checkOutput("reset_mid_shift", 19'b0_000000_100000_00_00_00, ALL_BITS);
    clockOne();
    WRSTN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    loadInstr(6'b000010, 6);
    checkOutput("resume_intest", 19'b0_000010_001000_11_00_00, ALL_BITS);

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
